// File: rtl/act_fold_layer.sv
// Folded activation layer: ReLU / leaky ReLU / clamped ReLU with requantisation,
// LANES elements per cycle over INPUT_NUM/LANES cycles, vector valid/ready handshake.
module act_fold_layer #(
  parameter int INPUT_WIDTH  = 16,
  parameter int INPUT_NUM    = 64,
  parameter int OUTPUT_WIDTH = 8,
  parameter int LANES        = 8,
  parameter int MODE         = 0,
  parameter int LEAK_SHIFT   = 3,
  parameter int CLAMP_MAX    = 96,
  parameter int SHIFT        = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INPUT_WIDTH*INPUT_NUM-1:0]  data_in,
  input  logic                              data_in_vaild,
  output logic                              data_in_ready,
  output logic [OUTPUT_WIDTH*INPUT_NUM-1:0] data_out,
  output logic                              data_out_vaild,
  input  logic                              data_out_ready,
  output logic                              sat_flag
);

  localparam int NGROUP = INPUT_NUM / LANES;
  localparam int GW = (NGROUP > 1) ? $clog2(NGROUP) : 1;
  localparam int WW =
    ((INPUT_WIDTH > OUTPUT_WIDTH) ? INPUT_WIDTH : OUTPUT_WIDTH) + 1;
  localparam int GOW = LANES * OUTPUT_WIDTH;

  localparam logic [GW-1:0] LAST = GW'(NGROUP - 1);
  localparam logic signed [INPUT_WIDTH-1:0] CMAX =
    INPUT_WIDTH'(CLAMP_MAX);
  localparam logic signed [WW-1:0] OMAX =
    WW'((2 ** (OUTPUT_WIDTH - 1)) - 1);
  localparam logic signed [WW-1:0] OMIN = ~OMAX;

  if (LANES < 1 || (INPUT_NUM % LANES) != 0) begin : g_bad_lanes
    $error("act_fold_layer: LANES must divide INPUT_NUM");
  end

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t state, state_nx;

  logic [INPUT_WIDTH*INPUT_NUM-1:0]  in_reg;
  logic [OUTPUT_WIDTH*INPUT_NUM-1:0] out_reg;
  logic [GW-1:0]                     grp;
  logic                              sat_acc;
  logic [GOW-1:0]                    grp_y;
  logic                              grp_sat;
  logic                              accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // ready is gated by rst so it reads 0 throughout reset
  always_comb begin
    state_nx       = state;
    data_in_ready  = 1'b0;
    data_out_vaild = 1'b0;
    case (state)
      IDLE: begin
        data_in_ready = rst;
        if (data_in_vaild) state_nx = PROC;
      end
      PROC: begin
        if (grp == LAST) state_nx = DONE;
      end
      DONE: begin
        data_out_vaild = 1'b1;
        if (data_out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = data_in_vaild & data_in_ready;

  always_comb begin
    grp_y   = '0;
    grp_sat = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      logic signed [INPUT_WIDTH-1:0] x;
      logic signed [INPUT_WIDTH-1:0] a;
      logic signed [INPUT_WIDTH-1:0] b;
      logic signed [WW-1:0]          bw;
      x = in_reg[(int'(grp) * LANES + l) * INPUT_WIDTH +: INPUT_WIDTH];
      case (MODE)
        1:       a = x[INPUT_WIDTH-1] ? (x >>> LEAK_SHIFT) : x;
        2:       a = x[INPUT_WIDTH-1] ? '0 : ((x > CMAX) ? CMAX : x);
        default: a = x[INPUT_WIDTH-1] ? '0 : x;
      endcase
      b  = a >>> SHIFT;
      bw = WW'(b);
      if (bw > OMAX) begin
        grp_y[l*OUTPUT_WIDTH +: OUTPUT_WIDTH] = OMAX[OUTPUT_WIDTH-1:0];
        grp_sat = 1'b1;
      end else if (bw < OMIN) begin
        grp_y[l*OUTPUT_WIDTH +: OUTPUT_WIDTH] = OMIN[OUTPUT_WIDTH-1:0];
        grp_sat = 1'b1;
      end else begin
        grp_y[l*OUTPUT_WIDTH +: OUTPUT_WIDTH] = bw[OUTPUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_reg  <= '0;
      out_reg <= '0;
      grp     <= '0;
      sat_acc <= 1'b0;
    end else if (accept) begin
      in_reg  <= data_in;
      grp     <= '0;
      sat_acc <= 1'b0;
    end else if (state == PROC) begin
      out_reg[int'(grp) * GOW +: GOW] <= grp_y;
      sat_acc <= sat_acc | grp_sat;
      if (grp != LAST) grp <= grp + 1'b1;
    end
  end

  assign data_out = out_reg;
  assign sat_flag = sat_acc;

endmodule

// File: tb/tb_act_fold_layer.sv
// Self-checking bench for act_fold_layer: six parameterisations checked
// against an integer reference model, plus handshake and reset scenarios.
module tb_act_fold_layer;

  localparam int NI = 6;
  localparam int C_MODE [NI] = '{0, 1, 2, 2, 1, 2};
  localparam int C_LEAK [NI] = '{3, 3, 3, 3, 2, 3};
  localparam int C_CMAX [NI] = '{96, 96, 96, 96, 96, 1000};
  localparam int C_SHIFT[NI] = '{0, 0, 0, 2, 1, 3};
  localparam int C_NG   [NI] = '{8, 8, 8, 8, 1, 64};

  logic         clk;
  logic         rst;
  logic [1023:0] din   [NI];
  logic          vin   [NI];
  logic          rdy   [NI];
  logic [511:0]  dout  [NI];
  logic          vout  [NI];
  logic          dready[NI];
  logic          sat   [NI];

  int total;
  int bad;

  act_fold_layer u0 (
    .clk(clk), .rst(rst), .data_in(din[0]), .data_in_vaild(vin[0]),
    .data_in_ready(rdy[0]), .data_out(dout[0]), .data_out_vaild(vout[0]),
    .data_out_ready(dready[0]), .sat_flag(sat[0]));

  act_fold_layer #(.MODE(1)) u1 (
    .clk(clk), .rst(rst), .data_in(din[1]), .data_in_vaild(vin[1]),
    .data_in_ready(rdy[1]), .data_out(dout[1]), .data_out_vaild(vout[1]),
    .data_out_ready(dready[1]), .sat_flag(sat[1]));

  act_fold_layer #(.MODE(2)) u2 (
    .clk(clk), .rst(rst), .data_in(din[2]), .data_in_vaild(vin[2]),
    .data_in_ready(rdy[2]), .data_out(dout[2]), .data_out_vaild(vout[2]),
    .data_out_ready(dready[2]), .sat_flag(sat[2]));

  act_fold_layer #(.MODE(2), .SHIFT(2)) u3 (
    .clk(clk), .rst(rst), .data_in(din[3]), .data_in_vaild(vin[3]),
    .data_in_ready(rdy[3]), .data_out(dout[3]), .data_out_vaild(vout[3]),
    .data_out_ready(dready[3]), .sat_flag(sat[3]));

  act_fold_layer #(.LANES(64), .MODE(1), .LEAK_SHIFT(2), .SHIFT(1)) u4 (
    .clk(clk), .rst(rst), .data_in(din[4]), .data_in_vaild(vin[4]),
    .data_in_ready(rdy[4]), .data_out(dout[4]), .data_out_vaild(vout[4]),
    .data_out_ready(dready[4]), .sat_flag(sat[4]));

  act_fold_layer #(.LANES(1), .MODE(2), .CLAMP_MAX(1000), .SHIFT(3)) u5 (
    .clk(clk), .rst(rst), .data_in(din[5]), .data_in_vaild(vin[5]),
    .data_in_ready(rdy[5]), .data_out(dout[5]), .data_out_vaild(vout[5]),
    .data_out_ready(dready[5]), .sat_flag(sat[5]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int fdiv(input int n, input int d);
    return (n >= 0) ? (n / d) : -((-n + d - 1) / d);
  endfunction

  function automatic void model(input int k, input logic [1023:0] v,
                                output logic [511:0] y, output logic s);
    y = '0;
    s = 1'b0;
    for (int i = 0; i < 64; i++) begin
      logic [15:0] raw;
      int x;
      int a;
      int b;
      raw = v[i*16 +: 16];
      x = int'($signed(raw));
      case (C_MODE[k])
        1:       a = (x < 0) ? fdiv(x, 1 << C_LEAK[k]) : x;
        2:       a = (x < 0) ? 0 : ((x > C_CMAX[k]) ? C_CMAX[k] : x);
        default: a = (x < 0) ? 0 : x;
      endcase
      b = fdiv(a, 1 << C_SHIFT[k]);
      if (b > 127) begin
        b = 127;
        s = 1'b1;
      end else if (b < -128) begin
        b = -128;
        s = 1'b1;
      end
      y[i*8 +: 8] = 8'(b);
    end
  endfunction

  function automatic logic [1023:0] rand_vec();
    logic [1023:0] v;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 3) == 0)
        v[i*16 +: 16] = 16'($urandom);
      else
        v[i*16 +: 16] = 16'($urandom_range(0, 1200)) - 16'd600;
    end
    return v;
  endfunction

  // drives one vector through instance k and returns what was observed
  task automatic run_vec(input int k, input logic [1023:0] v,
                         output int lat, output logic [511:0] y,
                         output logic s);
    int n;
    @(negedge clk);
    din[k] = v;
    vin[k] = 1'b1;
    n = 0;
    while (!rdy[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 vin[k] = 1'b0;
    lat = 0;
    while (!vout[k] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    y = dout[k];
    s = sat[k];
    dready[k] = 1'b1;
    @(posedge clk);
    #1 dready[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    for (int k = 0; k < NI; k++) begin
      total++;
      if (dout[k] !== '0) begin
        bad++;
        $display("FAIL reset_dout k=%0d got=%h want=0", k, dout[k]);
      end
      total++;
      if (vout[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_vout k=%0d got=%b want=0", k, vout[k]);
      end
      total++;
      if (sat[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_sat k=%0d got=%b want=0", k, sat[k]);
      end
      total++;
      if (rdy[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_rdy k=%0d got=%b want=0", k, rdy[k]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      total++;
      if (rdy[k] !== 1'b1) begin
        bad++;
        $display("FAIL post_reset_rdy k=%0d got=%b want=1", k, rdy[k]);
      end
    end
  endtask

  task automatic test_directed();
    logic [1023:0] v;
    logic [511:0]  y;
    logic [511:0]  e;
    logic          s;
    int            lat;
    v = '0;
    v[15:0] = -16'sd5;
    v[31:16] = 16'd100;
    v[47:32] = 16'd200;
    e = '0;
    e[15:8] = 8'd100;
    e[23:16] = 8'd127;
    run_vec(0, v, lat, y, s);
    total++;
    if (y !== e || s !== 1'b1 || lat !== 8) begin
      bad++;
      $display("FAIL relu_dir got=%h s=%b lat=%0d want=%h s=1 lat=8",
               y, s, lat, e);
    end
    v = '0;
    v[15:0] = -16'sd16;
    v[31:16] = -16'sd1;
    v[47:32] = -16'sd2000;
    e = '0;
    e[7:0] = 8'hFE;
    e[15:8] = 8'hFF;
    e[23:16] = 8'h80;
    run_vec(1, v, lat, y, s);
    total++;
    if (y !== e || s !== 1'b1) begin
      bad++;
      $display("FAIL leaky_dir got=%h s=%b want=%h s=1", y, s, e);
    end
    v = '0;
    v[15:0] = 16'd120;
    v[31:16] = -16'sd3;
    v[47:32] = 16'd50;
    e = '0;
    e[7:0] = 8'd96;
    e[23:16] = 8'd50;
    run_vec(2, v, lat, y, s);
    total++;
    if (y !== e || s !== 1'b0) begin
      bad++;
      $display("FAIL clamp_dir got=%h s=%b want=%h s=0", y, s, e);
    end
    e = '0;
    e[7:0] = 8'd24;
    e[23:16] = 8'd12;
    run_vec(3, v, lat, y, s);
    total++;
    if (y !== e || s !== 1'b0) begin
      bad++;
      $display("FAIL clamp_shift_dir got=%h s=%b want=%h s=0", y, s, e);
    end
  endtask

  task automatic test_random_modes();
    logic [1023:0] v;
    logic [511:0]  y;
    logic [511:0]  e;
    logic          s;
    logic          es;
    int            lat;
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 4; r++) begin
        v = rand_vec();
        model(k, v, e, es);
        run_vec(k, v, lat, y, s);
        total++;
        if (y !== e || s !== es || lat !== C_NG[k]) begin
          bad++;
          $display("FAIL rand_k%0d got=%h s=%b lat=%0d want=%h s=%b lat=%0d",
                   k, y, s, lat, e, es, C_NG[k]);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [1023:0] va;
    logic [1023:0] vb;
    logic [511:0]  ea;
    logic [511:0]  eb;
    logic          sa;
    logic          sb;
    int            n;
    va = rand_vec();
    vb = rand_vec();
    model(0, va, ea, sa);
    model(0, vb, eb, sb);
    @(negedge clk);
    din[0] = va;
    vin[0] = 1'b1;
    @(posedge clk);
    #1 vin[0] = 1'b0;
    n = 0;
    while (!vout[0] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n !== 8) begin
      bad++;
      $display("FAIL hold_lat got=%0d want=8", n);
    end
    din[0] = vb;
    vin[0] = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      total++;
      if (dout[0] !== ea || sat[0] !== sa) begin
        bad++;
        $display("FAIL hold_stable got=%h s=%b want=%h s=%b",
                 dout[0], sat[0], ea, sa);
      end
      total++;
      if (rdy[0] !== 1'b0 || vout[0] !== 1'b1) begin
        bad++;
        $display("FAIL hold_hs rdy=%b vout=%b want rdy=0 vout=1",
                 rdy[0], vout[0]);
      end
    end
    dready[0] = 1'b1;
    @(posedge clk);
    #1 dready[0] = 1'b0;
    total++;
    if (vout[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      bad++;
      $display("FAIL hold_release vout=%b rdy=%b want vout=0 rdy=1",
               vout[0], rdy[0]);
    end
    @(posedge clk);
    #1 vin[0] = 1'b0;
    total++;
    if (rdy[0] !== 1'b0) begin
      bad++;
      $display("FAIL hold_next_accept rdy=%b want=0", rdy[0]);
    end
    n = 0;
    while (!vout[0] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n !== 8 || dout[0] !== eb || sat[0] !== sb) begin
      bad++;
      $display("FAIL hold_second got=%h s=%b lat=%0d want=%h s=%b lat=8",
               dout[0], sat[0], n, eb, sb);
    end
    dready[0] = 1'b1;
    @(posedge clk);
    #1 dready[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1023:0] v;
    logic [511:0]  y;
    logic [511:0]  e;
    logic          s;
    logic          es;
    logic          seen;
    int            lat;
    v = rand_vec();
    v[15:0] = 16'd30000;
    @(negedge clk);
    din[0] = v;
    vin[0] = 1'b1;
    @(posedge clk);
    #1 vin[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (dout[0] !== '0 || vout[0] !== 1'b0 || sat[0] !== 1'b0 ||
        rdy[0] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_out dout=%h v=%b s=%b r=%b want all 0",
               dout[0], vout[0], sat[0], rdy[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (rdy[0] !== 1'b1) begin
      bad++;
      $display("FAIL midreset_idle rdy=%b want=1", rdy[0]);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (vout[0] === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL midreset_novalid got=%b want=0", seen);
    end
    v = rand_vec();
    model(0, v, e, es);
    run_vec(0, v, lat, y, s);
    total++;
    if (y !== e || s !== es || lat !== 8) begin
      bad++;
      $display("FAIL midreset_next got=%h s=%b lat=%0d want=%h s=%b lat=8",
               y, s, lat, e, es);
    end
  endtask

  task automatic test_lane_sweep();
    logic [1023:0] v;
    logic [511:0]  y;
    logic [511:0]  e;
    logic          s;
    logic          es;
    int            lat;
    for (int k = 4; k < NI; k++) begin
      for (int r = 0; r < 3; r++) begin
        v = rand_vec();
        model(k, v, e, es);
        run_vec(k, v, lat, y, s);
        total++;
        if (y !== e || s !== es || lat !== C_NG[k]) begin
          bad++;
          $display("FAIL sweep_k%0d got=%h s=%b lat=%0d want=%h s=%b lat=%0d",
                   k, y, s, lat, e, es, C_NG[k]);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int k = 0; k < NI; k++) begin
      din[k] = '0;
      vin[k] = 1'b0;
      dready[k] = 1'b0;
    end
    test_reset();
    test_directed();
    test_random_modes();
    test_hold();
    test_reset_mid();
    test_lane_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
